// File: rtl/audio_pwm_stream.sv
// ---------------------------------------------------------------------------
// audio_pwm_stream
//
// Multi-channel PWM audio output stage. Signed PCM frames arrive over a
// valid/ready stream into a small frame FIFO. Once the FIFO holds at least
// half its depth, one frame is popped per PWM period. Each popped frame is
// scaled by the digital volume and converted to a per-channel duty value.
// Dropping game_active stops playback and flushes everything.
//
// Ports:
//   clk_audio     in   audio clock
//   rst_n         in   asynchronous active-low reset
//   game_active   in   1 = play, 0 = stop and flush
//   sample_valid  in   frame valid
//   sample_ready  out  frame accepted when valid && ready
//   sample_data   in   one frame, channel 0 in the LSBs
//   volume        in   unsigned gain (volume / 2^VOL_W), sampled at each pop
//   pwm_out       out  registered PWM, one bit per channel
//   fifo_level    out  frames currently buffered
//   playing       out  high while in PLAY
//   underrun      out  one-cycle pulse when a pop was due but FIFO was empty
//   underrun_cnt  out  saturating underrun count, cleared on each start
// ---------------------------------------------------------------------------
module audio_pwm_stream #(
    parameter int DATA_W     = 16,
    parameter int PWM_W      = 8,
    parameter int CHANNELS   = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int VOL_W      = 4
) (
    input  logic                            clk_audio,
    input  logic                            rst_n,
    input  logic                            game_active,
    input  logic                            sample_valid,
    output logic                            sample_ready,
    input  logic [CHANNELS*DATA_W-1:0]      sample_data,
    input  logic [VOL_W-1:0]                volume,
    output logic [CHANNELS-1:0]             pwm_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            playing,
    output logic                            underrun,
    output logic [7:0]                      underrun_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_PRIME = LVL_W'(FIFO_DEPTH / 2);

    typedef enum logic [1:0] {IDLE, PRIME, PLAY} state_t;

    state_t                     r_state;
    logic [PWM_W-1:0]           r_pwm_cnt;
    logic [CHANNELS*DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]           r_wr_ptr;
    logic [PTR_W-1:0]           r_rd_ptr;
    logic [LVL_W-1:0]           r_level;
    logic [PWM_W-1:0]           r_duty_p0 [CHANNELS];
    logic [CHANNELS-1:0]        r_pwm_p1;
    logic                       r_underrun;
    logic [7:0]                 r_underrun_cnt;

    logic                       w_wrap;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_miss;
    logic [CHANNELS*DATA_W-1:0] w_head;

    // Scale one sample by volume and map it to an offset-binary duty value.
    // The product is sign-extended to DATA_W+VOL_W+1 bits so the unsigned
    // volume never flips the sign; after the shift the result always fits
    // back into DATA_W bits because the gain is below 1.
    function automatic logic [PWM_W-1:0] f_duty(
        input logic signed [DATA_W-1:0] s,
        input logic        [VOL_W-1:0]  vol
    );
        logic signed [DATA_W+VOL_W:0] s_x;
        logic signed [DATA_W+VOL_W:0] v_x;
        logic signed [DATA_W+VOL_W:0] p;
        logic signed [DATA_W-1:0]     q;
        logic        [DATA_W-1:0]     u;
        s_x = {{(VOL_W + 1){s[DATA_W-1]}}, s};
        v_x = {{(DATA_W + 1){1'b0}}, vol};
        p   = s_x * v_x;
        q   = DATA_W'(p >>> VOL_W);
        u   = {~q[DATA_W-1], q[DATA_W-2:0]};
        return PWM_W'(u >> (DATA_W - PWM_W));
    endfunction

    assign w_wrap       = (r_pwm_cnt == {PWM_W{1'b1}});
    assign w_full       = (r_level == LVL_FULL);
    assign w_empty      = (r_level == '0);
    assign sample_ready = game_active && !w_full && (r_state != IDLE);
    assign w_push       = sample_valid && sample_ready;
    assign w_pop        = game_active && w_wrap &&
                          (((r_state == PLAY) && !w_empty) ||
                           ((r_state == PRIME) && (r_level >= LVL_PRIME)));
    assign w_miss       = game_active && w_wrap && (r_state == PLAY) && w_empty;
    assign w_head       = r_mem[r_rd_ptr];

    // Frame storage carries data only, so it has no reset.
    always_ff @(posedge clk_audio) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= sample_data;
        end
    end

    always_ff @(posedge clk_audio or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_pwm_cnt      <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_pwm_p1       <= '0;
            r_underrun     <= 1'b0;
            r_underrun_cnt <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_duty_p0[c] <= '0;
            end
        end else if (!game_active) begin
            // Stop: flush the FIFO and silence the outputs, keep the count.
            r_state    <= IDLE;
            r_pwm_cnt  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_pwm_p1   <= '0;
            r_underrun <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_duty_p0[c] <= '0;
            end
        end else begin
            r_underrun <= w_miss;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
            if (w_miss && (r_underrun_cnt != 8'hFF)) begin
                r_underrun_cnt <= r_underrun_cnt + 1'b1;
            end

            // Stage p0: duty loads on the pop (wrap) cycle, so it is in
            // effect from pwm_cnt == 0 of the next period.
            if (w_pop) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    r_duty_p0[c] <= f_duty(w_head[c*DATA_W +: DATA_W], volume);
                end
            end

            // Stage p1: registered comparator, one cycle behind pwm_cnt.
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            for (int c = 0; c < CHANNELS; c++) begin
                r_pwm_p1[c] <= (r_pwm_cnt < r_duty_p0[c]);
            end

            case (r_state)
                IDLE: begin
                    r_pwm_cnt      <= '0;
                    r_pwm_p1       <= '0;
                    r_underrun_cnt <= '0;
                    r_state        <= PRIME;
                end
                PRIME: begin
                    if (w_pop) begin
                        r_state <= PLAY;
                    end
                end
                PLAY: begin
                    r_state <= PLAY;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign pwm_out      = r_pwm_p1;
    assign fifo_level   = r_level;
    assign playing      = (r_state == PLAY);
    assign underrun     = r_underrun;
    assign underrun_cnt = r_underrun_cnt;

endmodule

// File: tb/tb_audio_pwm_stream.sv
// ---------------------------------------------------------------------------
// tb_audio_pwm_stream
//
// Directed bench for audio_pwm_stream with default parameters. Stimulus
// pushes the expected per-period high counts and expected underrun counts
// into queues; a monitor measures each PWM period once playing is high and
// checks it against the queue head.
// ---------------------------------------------------------------------------
module tb_audio_pwm_stream;

    localparam int PER = 256;

    logic        clk_audio    = 1'b0;
    logic        rst_n        = 1'b0;
    logic        game_active  = 1'b0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic [31:0] sample_data  = '0;
    logic [3:0]  volume       = '0;
    logic [1:0]  pwm_out;
    logic [3:0]  fifo_level;
    logic        playing;
    logic        underrun;
    logic [7:0]  underrun_cnt;

    int total = 0;
    int bad   = 0;
    int exp_q[$];   // {ch1_high << 16 | ch0_high} per PWM period
    int uc_q[$];    // expected underrun_cnt at each underrun pulse

    always #5 clk_audio = ~clk_audio;

    audio_pwm_stream dut (
        .clk_audio    (clk_audio),
        .rst_n        (rst_n),
        .game_active  (game_active),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_data  (sample_data),
        .volume       (volume),
        .pwm_out      (pwm_out),
        .fifo_level   (fifo_level),
        .playing      (playing),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] c0, input logic [15:0] c1);
        int n = 0;
        sample_data  = {c1, c0};
        sample_valid = 1'b1;
        while (!sample_ready && n < 2000) begin
            @(negedge clk_audio);
            n++;
        end
        if (!sample_ready) begin
            total++;
            bad++;
            $display("FAIL push_timeout: ready stayed %0d, expected 1", sample_ready);
        end
        @(negedge clk_audio);
        sample_valid = 1'b0;
    endtask

    task automatic wait_playing();
        int n = 0;
        while (!playing && n < 2000) begin
            @(negedge clk_audio);
            n++;
        end
        if (!playing) begin
            total++;
            bad++;
            $display("FAIL playing_timeout: playing stayed %0d, expected 1", playing);
        end
    endtask

    task automatic expect_period(input int h0, input int h1, input int reps);
        repeat (reps) exp_q.push_back((h1 << 16) | h0);
    endtask

    task automatic stop_and_check(input int uc);
        game_active = 1'b0;
        @(negedge clk_audio);
        chk("stop_playing", int'(playing), 0);
        chk("stop_level", int'(fifo_level), 0);
        chk("stop_pwm", int'(pwm_out), 0);
        chk("stop_ucnt", int'(underrun_cnt), uc);
    endtask

    // Monitor: period p covers the cycles ph = PER*p+1 .. PER*p+PER after
    // playing rises, because pwm_out trails pwm_cnt by one cycle.
    initial begin
        int ph;
        int acc0;
        int acc1;
        int e;
        ph = 0;
        acc0 = 0;
        acc1 = 0;
        forever begin
            @(negedge clk_audio);
            if (underrun) begin
                if (uc_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL underrun_unexpected: cnt=%0d, no pulse expected", underrun_cnt);
                end else begin
                    e = uc_q.pop_front();
                    chk("underrun_cnt", int'(underrun_cnt), e);
                end
            end
            if (!playing) begin
                ph = 0;
                acc0 = 0;
                acc1 = 0;
            end else begin
                if (ph > 0) begin
                    acc0 += int'(pwm_out[0]);
                    acc1 += int'(pwm_out[1]);
                    if (ph % PER == 0) begin
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL period_unexpected: highs=%0d/%0d, no period expected", acc0, acc1);
                        end else begin
                            e = exp_q.pop_front();
                            chk("ch0_high", acc0, e & 32'hFFFF);
                            chk("ch1_high", acc1, e >> 16);
                        end
                        acc0 = 0;
                        acc1 = 0;
                    end
                end
                ph++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: sim time %0t, expected finish earlier", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int errs;

        // Reset values
        repeat (3) @(negedge clk_audio);
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_playing", int'(playing), 0);
        chk("rst_underrun", int'(underrun), 0);
        chk("rst_ucnt", int'(underrun_cnt), 0);
        chk("rst_ready", int'(sample_ready), 0);

        // Idle with valid asserted: nothing accepted, nothing driven
        rst_n        = 1'b1;
        sample_valid = 1'b1;
        sample_data  = 32'h8000_4000;
        errs = 0;
        repeat (1000) begin
            @(negedge clk_audio);
            if (pwm_out != 0 || sample_ready || playing || fifo_level != 0 || underrun)
                errs++;
        end
        chk("idle_quiet_cycles", errs, 0);
        sample_valid = 1'b0;

        // Volume 8: 0x4000 -> 0x2000 -> duty 0xA0; 0x8000 -> 0xC000 -> duty 0x40
        volume = 4'd8;
        game_active = 1'b1;
        repeat (4) push(16'h4000, 16'h8000);
        expect_period(160, 64, 3);
        wait_playing();
        repeat (3*PER + 10) @(negedge clk_audio);
        stop_and_check(0);

        // Volume 15: 0x3C00 -> 0xBC; 0x8800 -> 0x08
        volume = 4'd15;
        game_active = 1'b1;
        repeat (4) push(16'h4000, 16'h8000);
        expect_period(188, 8, 3);
        wait_playing();
        repeat (3*PER + 10) @(negedge clk_audio);
        stop_and_check(0);

        // Four distinct frames then starvation: duty holds, underruns count
        volume = 4'd8;
        game_active = 1'b1;
        push(16'h4000, 16'h8000);
        push(16'h0000, 16'h1000);
        push(16'h7FFF, 16'hFFFF);
        push(16'hC000, 16'h2000);
        expect_period(160, 64, 1);
        expect_period(128, 136, 1);
        expect_period(191, 127, 1);
        expect_period(96, 144, 4);
        for (int i = 1; i <= 4; i++) uc_q.push_back(i);
        wait_playing();
        repeat (7*PER + 10) @(negedge clk_audio);
        stop_and_check(4);

        // Restart clears the underrun count
        game_active = 1'b1;
        @(negedge clk_audio);
        chk("restart_ucnt", int'(underrun_cnt), 0);
        chk("restart_ready", int'(sample_ready), 1);

        // Fill to full, pop, simultaneous push/pop, then stop at level 5
        volume = 4'd15;
        repeat (8) push(16'h4000, 16'h8000);
        sample_data  = 32'h8000_4000;
        sample_valid = 1'b1;
        chk("full_level", int'(fifo_level), 8);
        chk("full_ready", int'(sample_ready), 0);
        expect_period(188, 8, 3);
        wait_playing();
        chk("first_pop_level", int'(fifo_level), 7);
        chk("first_pop_ready", int'(sample_ready), 1);
        sample_valid = 1'b0;
        repeat (PER - 1) @(negedge clk_audio);
        sample_valid = 1'b1;
        @(negedge clk_audio);
        chk("push_pop_level", int'(fifo_level), 7);
        sample_valid = 1'b0;
        repeat (2*PER + 10) @(negedge clk_audio);
        chk("pre_stop_level", int'(fifo_level), 5);
        stop_and_check(0);

        // Volume 0 gives midscale, then async reset mid-play
        volume = 4'd0;
        game_active = 1'b1;
        repeat (4) push(16'h7FFF, 16'h8000);
        expect_period(128, 128, 2);
        wait_playing();
        repeat (2*PER + 10) @(negedge clk_audio);
        chk("pre_reset_level", int'(fifo_level), 1);
        chk("pre_reset_pwm", int'(pwm_out), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_playing", int'(playing), 0);
        chk("async_rst_level", int'(fifo_level), 0);
        chk("async_rst_pwm", int'(pwm_out), 0);
        chk("async_rst_ready", int'(sample_ready), 0);
        @(negedge clk_audio);
        game_active = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk_audio);

        chk("periods_left", exp_q.size(), 0);
        chk("underruns_left", uc_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
